// File: rtl/led_pkg.sv
// Shared definitions for the four-digit LED display driver.
//   led_state_t : slot state, DEAD (anodes off) or ON (one anode driven).
//   GLYPH_*     : active-low cathode patterns {g,f,e,d,c,b,a}.
//   ERROR_WORD  : word sent by the two-byte receive register on error.
//                 It decodes to "CCCC" on the display.
package led_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } led_state_t;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;

    localparam logic [15:0] ERROR_WORD = 16'hCCCC;

endpackage

// File: rtl/led_nibble_decoder.sv
// Hex nibble to active-low seven-segment glyph, purely combinational.
//   nibble : 4-bit value 0..F
//   seg    : cathodes {g,f,e,d,c,b,a}, active-low
module led_nibble_decoder
    import led_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (nibble)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = GLYPH_A;
            4'hB:    seg = GLYPH_B;
            4'hC:    seg = GLYPH_C;
            4'hD:    seg = GLYPH_D;
            4'hE:    seg = GLYPH_E;
            default: seg = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/four_digit_led_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// The 16-bit word arrives asynchronously, is synchronised, filtered for
// two consecutive equal samples, and copied into a shadow word only at
// frame boundaries so a frame never mixes old and new nibbles.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   char_word  : display word, async to clk; [15:12] -> an[3], [3:0] -> an[0]
//   an         : digit anodes, active-low
//   seg        : cathodes {g,f,e,d,c,b,a}, active-low
//   frame_tick : one-cycle pulse after the shadow word is loaded
//   state      : current slot state (DEAD / ON), for observation
//
// Build option: define LED_BLANK_ZERO_EN for leading-zero suppression
// (digit 0 is never blanked). Timing and anodes do not change.
module four_digit_led_driver
    import led_pkg::*;
#(
    parameter int SLOT_CYCLES = 16,
    parameter int DEAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] char_word,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick,
    output led_state_t  state
);

    if (SLOT_CYCLES < 4 || SLOT_CYCLES > 65535 ||
        DEAD_CYCLES < 1 || DEAD_CYCLES >= SLOT_CYCLES) begin : g_param_check
        $fatal(1, "four_digit_led_driver: illegal SLOT_CYCLES/DEAD_CYCLES");
    end

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

    logic [15:0]   sync1, sync2, prev, stable, shadow;
    logic [CW-1:0] cnt;
    logic [1:0]    digit;

    logic          load;
    logic [15:0]   shadow_next;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          blank;
    logic [6:0]    seg_next;

    // Two-flop synchroniser plus a history register; the stable word only
    // follows when two consecutive synchronised samples agree, which masks
    // bits that resolved on different edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            stable <= '0;
        end else begin
            sync1 <= char_word;
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2 == prev) begin
                stable <= sync2;
            end
        end
    end

    // The first DEAD cycle of digit 3 is the frame boundary; this also holds
    // right after reset, where the FSM starts in exactly that position.
    always_comb begin
        load        = (state == DEAD) && (cnt == '0) && (digit == 2'd3);
        shadow_next = load ? stable : shadow;
        nibble      = 4'h0;
        case (digit)
            2'd3: nibble = shadow_next[15:12];
            2'd2: nibble = shadow_next[11:8];
            2'd1: nibble = shadow_next[7:4];
            2'd0: nibble = shadow_next[3:0];
        endcase
    end

    led_nibble_decoder u_decoder (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef LED_BLANK_ZERO_EN
    logic lead3, lead2, lead1;

    // A digit is a leading zero when it and every digit to its left are 0.
    always_comb begin
        lead3 = (shadow_next[15:12] == 4'h0);
        lead2 = lead3 && (shadow_next[11:8] == 4'h0);
        lead1 = lead2 && (shadow_next[7:4] == 4'h0);
        blank = 1'b0;
        case (digit)
            2'd3: blank = lead3;
            2'd2: blank = lead2;
            2'd1: blank = lead1;
            2'd0: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? GLYPH_BLANK : glyph;

    // Slot FSM. an is updated on the same edge as the state so that anodes
    // are off exactly while state is DEAD. seg is refreshed during DEAD and
    // frozen during ON, so the lit digit never sees a cathode change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DEAD;
            cnt        <= '0;
            digit      <= 2'd3;
            an         <= 4'b1111;
            seg        <= GLYPH_BLANK;
            frame_tick <= 1'b0;
            shadow     <= '0;
        end else begin
            frame_tick <= load;
            shadow     <= shadow_next;
            cnt        <= (cnt == SLOT_LAST) ? '0 : cnt + 1'b1;
            case (state)
                DEAD: begin
                    seg <= seg_next;
                    if (cnt == DEAD_LAST) begin
                        state <= ON;
                        an    <= ~(4'b0001 << digit);
                    end else begin
                        an <= 4'b1111;
                    end
                end
                ON: begin
                    if (cnt == SLOT_LAST) begin
                        state <= DEAD;
                        an    <= 4'b1111;
                        digit <= digit - 2'd1;
                    end
                end
                default: state <= DEAD;
            endcase
        end
    end

endmodule

// File: tb/tb_four_digit_led_driver.sv
// Directed bench for four_digit_led_driver (SLOT_CYCLES=16, DEAD_CYCLES=2).
// Expected glyphs come from a bench-side hex table and leading-zero model,
// queued per frame and popped slot by slot. Outputs are sampled on the
// falling clock edge.
module tb_four_digit_led_driver;
    import led_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] char_word = 16'h1234;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;
    led_state_t  fsm_state;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_q[$];
    logic [6:0] glyph_tab [16];

    four_digit_led_driver #(
        .SLOT_CYCLES (16),
        .DEAD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_word  (char_word),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick),
        .state      (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input logic [15:0] w, input int d);
        logic [3:0] nib;
        logic       lead;
        nib  = w[4*d +: 4];
        lead = 1'b1;
        for (int j = 3; j >= d; j--) begin
            if (w[4*j +: 4] != 4'h0) lead = 1'b0;
        end
`ifdef LED_BLANK_ZERO_EN
        if (lead && d != 0) return 7'b1111111;
`endif
        return glyph_tab[nib];
    endfunction

    task automatic push_word(input logic [15:0] w);
        for (int d = 3; d >= 0; d--) exp_q.push_back(exp_glyph(w, d));
    endtask

    // Entered at the falling edge where the slot counter is 0; leaves at the
    // falling edge where the next slot's counter is 0.
    // act: 0 none, 1 load val into char_word at ON cycle 5,
    //      2 two one-cycle single-bit glitches around val starting at cycle 5.
    task automatic run_slot(input int d, input logic [6:0] g, input logic tick,
                            input int act, input logic [15:0] val);
        logic [3:0] an_on;
        an_on    = 4'b1111;
        an_on[d] = 1'b0;
        check("dead0_an", an, 4'b1111);
        check("dead0_tick", frame_tick, 1'b0);
        @(negedge clk);
        check("dead1_an", an, 4'b1111);
        check("dead1_tick", frame_tick, tick);
        check("dead1_state", fsm_state, DEAD);
        for (int i = 2; i < 16; i++) begin
            @(negedge clk);
            check("on_an", an, an_on);
            check("on_seg", seg, g);
            check("on_tick", frame_tick, 1'b0);
            if (act == 1 && i == 5) char_word = val;
            if (act == 2) begin
                if (i == 5)      char_word = val ^ 16'h0001;
                else if (i == 6) char_word = val ^ 16'h0100;
                else if (i == 7) char_word = val;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input int act_digit, input int act, input logic [15:0] val);
        logic [6:0] g;
        for (int d = 3; d >= 0; d--) begin
            g = exp_q.pop_front();
            run_slot(d, g, (d == 3), (d == act_digit) ? act : 0, val);
        end
    endtask

    initial begin
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // reset held low with a steady word
        reset     = 1'b0;
        char_word = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_an", an, 4'b1111);
            check("rst_seg", seg, 7'b1111111);
            check("rst_tick", frame_tick, 1'b0);
            check("rst_state", fsm_state, DEAD);
        end
        reset = 1'b1;

        // first frame loads the not-yet-settled stable word (0)
        push_word(16'h0000);
        run_frame(-1, 0, 16'h0);

        // 1234, changed to ABCD while digit 1 is lit: frame stays 1,2,3,4
        push_word(16'h1234);
        run_frame(1, 1, 16'hABCD);

        // ABCD, with a two-cycle glitch burst during digit 3
        push_word(16'hABCD);
        run_frame(3, 2, 16'hABCD);

        // glitch must not have reached the display; error word arrives now
        char_word = ERROR_WORD;
        push_word(16'hABCD);
        run_frame(-1, 0, 16'h0);

        push_word(16'hCCCC);
        char_word = 16'h0050;
        run_frame(-1, 0, 16'h0);

        push_word(16'h0050);
        run_frame(-1, 0, 16'h0);

        // reset pulse during digit 2 ON
        run_slot(3, exp_glyph(16'h0050, 3), 1'b1, 0, 16'h0);
        repeat (8) @(negedge clk);
        check("pre_rst_an", an, 4'b1011);
        check("pre_rst_state", fsm_state, ON);
        reset = 1'b0;
        #1;
        check("async_rst_an", an, 4'b1111);
        check("async_rst_seg", seg, 7'b1111111);
        check("async_rst_tick", frame_tick, 1'b0);
        check("async_rst_state", fsm_state, DEAD);
        repeat (3) @(negedge clk);
        check("held_rst_an", an, 4'b1111);
        reset = 1'b1;

        // restart at digit 3 with a frame tick; stable was cleared by reset
        push_word(16'h0000);
        run_frame(-1, 0, 16'h0);
        push_word(16'h0050);
        run_frame(-1, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
